// File: rtl/beep_pkg.sv
// Shared constants for the buzzer tone generators and the tone decoder:
// nominal note periods at 100 MHz, note codes and decoder FSM states.
package beep_pkg;

    localparam int unsigned CLK_HZ    = 100000000;
    localparam int          NUM_NOTES = 10;

    localparam logic [3:0] NOTE_SILENT = 4'd0;
    localparam logic [3:0] NOTE_UNK    = 4'd15;

    typedef enum logic [1:0] {
        SILENT,
        ARMED,
        MEASURE
    } dec_state_e;

    // Index 0..9 maps to note codes 1..10 (C4 .. D5).
    function automatic logic [19:0] note_period(input int idx);
        case (idx)
            0:       return 20'd381679;
            1:       return 20'd340136;
            2:       return 20'd303030;
            3:       return 20'd286533;
            4:       return 20'd270270;
            5:       return 20'd255102;
            6:       return 20'd227273;
            7:       return 20'd202429;
            8:       return 20'd191205;
            9:       return 20'd170358;
            default: return 20'd0;
        endcase
    endfunction

endpackage

// File: rtl/beep_note_lookup.sv
// Combinational period -> note code classifier. With BEEP_DEC_DUTY_CHECK_EN
// defined, a high time far from half the period also forces NOTE_UNK.
module beep_note_lookup
    import beep_pkg::*;
#(
    parameter int TOL_SHIFT  = 6,
    parameter int NOTE_SHIFT = 0
) (
    input  logic [19:0] period,
`ifdef BEEP_DEC_DUTY_CHECK_EN
    input  logic [19:0] high_time,
`endif
    output logic [3:0]  code
);

    logic [19:0] nom;
    logic [19:0] tol;
    logic [20:0] diff;
`ifdef BEEP_DEC_DUTY_CHECK_EN
    logic [19:0] half;
    logic [20:0] ddiff;
`endif

    always_comb begin
        code = NOTE_UNK;
        nom  = '0;
        tol  = '0;
        diff = '0;
        for (int i = 0; i < NUM_NOTES; i++) begin
            // NOTE_SHIFT scales the table down for short simulations; 0 in silicon.
            nom  = note_period(i) >> NOTE_SHIFT;
            tol  = nom >> TOL_SHIFT;
            diff = (period >= nom) ? ({1'b0, period} - {1'b0, nom})
                                   : ({1'b0, nom} - {1'b0, period});
            if (diff <= {1'b0, tol}) begin
                code = 4'(i + 1);
            end
        end
`ifdef BEEP_DEC_DUTY_CHECK_EN
        half  = period >> 1;
        ddiff = (high_time >= half) ? ({1'b0, high_time} - {1'b0, half})
                                    : ({1'b0, half} - {1'b0, high_time});
        if (ddiff > {1'b0, period >> TOL_SHIFT}) begin
            code = NOTE_UNK;
        end
`endif
    end

endmodule

// File: rtl/beep_tone_decoder.sv
// Tone-line note decoder: period measurement, note-table match, debounce and
// silence detection. Optional duty check under BEEP_DEC_DUTY_CHECK_EN.
module beep_tone_decoder
    import beep_pkg::*;
#(
    parameter int TIMEOUT    = 500000,
    parameter int TOL_SHIFT  = 6,
    parameter int STABLE_N   = 2,
    parameter int NOTE_SHIFT = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tone_in,
    output logic        note_valid,
    output logic [3:0]  note_code,
    output logic [19:0] period
);

    localparam logic [19:0] TIMEOUT_C = 20'(TIMEOUT);
    localparam logic [3:0]  STABLE_C  = 4'(STABLE_N);

    logic        sync1_q, sync1_d, sync2_q, sync2_d, lvl_q, lvl_d, rise_q, rise_d;
    dec_state_e  state_q, state_d;
    logic [19:0] cnt_q, cnt_d;
    logic [19:0] period_q, period_d;
    logic        meas_q, meas_d;
    logic        sil_q, sil_d;
    logic [3:0]  last_code_q, last_code_d;
    logic [3:0]  run_q, run_d;
    logic [3:0]  note_code_q, note_code_d;
    logic        note_valid_q, note_valid_d;
    logic [3:0]  code;
`ifdef BEEP_DEC_DUTY_CHECK_EN
    logic [19:0] hi_q, hi_d, hi_cap_q, hi_cap_d;
`endif

    always_comb begin
        sync1_d = tone_in;
        sync2_d = sync1_q;
        lvl_d   = sync2_q;
        rise_d  = sync2_q & ~lvl_q;
    end

    // Period FSM: meas_q flags a fresh capture, sil_q a silence event.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        meas_d   = 1'b0;
        sil_d    = 1'b0;
`ifdef BEEP_DEC_DUTY_CHECK_EN
        hi_d     = hi_q;
        hi_cap_d = hi_cap_q;
`endif
        case (state_q)
            SILENT: begin
                if (rise_q) begin
                    state_d = ARMED;
                    cnt_d   = 20'd1;
                end
`ifdef BEEP_DEC_DUTY_CHECK_EN
                hi_d = rise_q ? {19'd0, lvl_q} : 20'd0;
`endif
            end
            default: begin
                if (rise_q) begin
                    period_d = cnt_q;
                    meas_d   = 1'b1;
                    cnt_d    = 20'd1;
                    state_d  = MEASURE;
`ifdef BEEP_DEC_DUTY_CHECK_EN
                    hi_cap_d = hi_q;
                    hi_d     = {19'd0, lvl_q};
`endif
                end else if (cnt_q == TIMEOUT_C) begin
                    state_d = SILENT;
                    cnt_d   = 20'd0;
                    sil_d   = 1'b1;
`ifdef BEEP_DEC_DUTY_CHECK_EN
                    hi_d    = 20'd0;
`endif
                end else begin
                    cnt_d = cnt_q + 20'd1;
`ifdef BEEP_DEC_DUTY_CHECK_EN
                    hi_d  = hi_q + {19'd0, lvl_q};
`endif
                end
            end
        endcase
    end

    beep_note_lookup #(
        .TOL_SHIFT (TOL_SHIFT),
        .NOTE_SHIFT(NOTE_SHIFT)
    ) u_lookup (
        .period   (period_q),
`ifdef BEEP_DEC_DUTY_CHECK_EN
        .high_time(hi_cap_q),
`endif
        .code     (code)
    );

    always_comb begin
        run_d        = run_q;
        last_code_d  = last_code_q;
        note_code_d  = note_code_q;
        note_valid_d = 1'b0;
        if (sil_q) begin
            run_d = 4'd0;
            if (note_code_q != NOTE_SILENT) begin
                note_code_d  = NOTE_SILENT;
                note_valid_d = 1'b1;
            end
        end else if (meas_q) begin
            if (code == last_code_q) begin
                run_d = (run_q >= STABLE_C) ? STABLE_C : run_q + 4'd1;
            end else begin
                run_d = 4'd1;
            end
            last_code_d = code;
            if (run_d == STABLE_C && code != note_code_q) begin
                note_code_d  = code;
                note_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            lvl_q        <= 1'b0;
            rise_q       <= 1'b0;
            state_q      <= SILENT;
            cnt_q        <= '0;
            period_q     <= '0;
            meas_q       <= 1'b0;
            sil_q        <= 1'b0;
            last_code_q  <= NOTE_SILENT;
            run_q        <= '0;
            note_code_q  <= NOTE_SILENT;
            note_valid_q <= 1'b0;
`ifdef BEEP_DEC_DUTY_CHECK_EN
            hi_q         <= '0;
            hi_cap_q     <= '0;
`endif
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            lvl_q        <= lvl_d;
            rise_q       <= rise_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            period_q     <= period_d;
            meas_q       <= meas_d;
            sil_q        <= sil_d;
            last_code_q  <= last_code_d;
            run_q        <= run_d;
            note_code_q  <= note_code_d;
            note_valid_q <= note_valid_d;
`ifdef BEEP_DEC_DUTY_CHECK_EN
            hi_q         <= hi_d;
            hi_cap_q     <= hi_cap_d;
`endif
        end
    end

    assign note_valid = note_valid_q;
    assign note_code  = note_code_q;
    assign period     = period_q;

endmodule
